// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and constants for the multicycle control FSM.
// Build option: CTRL_TRAP_EN (see mc_ctrl_fsm.sv).
package mc_ctrl_pkg;

  localparam int unsigned CTRL_BITS = 22;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_EXEC_I,
    ST_WB_I,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP,
    ST_JAL_LINK,
    ST_JR,
    ST_HALT,
    ST_TRAP
  } st_e;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_XORI = 6'd14;
  localparam logic [5:0] OP_LUI  = 6'd15;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_SYS  = 6'd12;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLT  = 6'd42;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_LUI   = 5'd7;
  localparam logic [4:0] ALU_SEQ   = 5'd8;
  localparam logic [4:0] ALU_PASSX = 5'd9;

  localparam int unsigned B_ALUF   = 0;
  localparam int unsigned B_ALUY   = 5;
  localparam int unsigned B_ALUX   = 7;
  localparam int unsigned B_DSEL0  = 8;
  localparam int unsigned B_DSEL1  = 9;
  localparam int unsigned B_REGIN  = 10;
  localparam int unsigned B_REGDST = 11;
  localparam int unsigned B_REGWR  = 13;
  localparam int unsigned B_IRWR   = 14;
  localparam int unsigned B_BRANCH = 15;
  localparam int unsigned B_PCSRC  = 16;
  localparam int unsigned B_MEMWR  = 18;
  localparam int unsigned B_MEMRD  = 19;
  localparam int unsigned B_INSTD  = 20;
  localparam int unsigned B_PCWR   = 21;

  localparam logic [1:0] Y_FOUR = 2'b00;
  localparam logic [1:0] Y_RT   = 2'b01;
  localparam logic [1:0] Y_IMM  = 2'b10;
  localparam logic [1:0] Y_IMM2 = 2'b11;

  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JTA    = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  function automatic logic r_legal(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR,
      FN_XOR, FN_NOR, FN_SLT: r_legal = 1'b1;
      default:                r_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] r_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_XOR:  r_alu = ALU_XOR;
      FN_NOR:  r_alu = ALU_NOR;
      FN_SLT:  r_alu = ALU_SLT;
      default: r_alu = ALU_ADD;
    endcase
  endfunction

  function automatic logic i_legal(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_SLTI, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI: i_legal = 1'b1;
      default:                 i_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] i_alu(input logic [5:0] op);
    case (op)
      OP_SLTI: i_alu = ALU_SLT;
      OP_ANDI: i_alu = ALU_AND;
      OP_ORI:  i_alu = ALU_OR;
      OP_XORI: i_alu = ALU_XOR;
      OP_LUI:  i_alu = ALU_LUI;
      default: i_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit bundle: instruction fields and memory handshake in,
// control vector and status out.
interface mc_ctrl_fsm_if #(
  parameter int CTRL_W = 22
) ();
  logic [5:0]        op_in;
  logic [5:0]        fn_in;
  logic              alu_zero;
  logic              mem_ready;
  logic [CTRL_W-1:0] ctrl_out;
  logic [3:0]        state_out;
  logic              halted;
  logic              illegal;

  modport master (
    input  op_in, fn_in, alu_zero, mem_ready,
    output ctrl_out, state_out, halted, illegal
  );

  modport slave (
    output op_in, fn_in, alu_zero, mem_ready,
    input  ctrl_out, state_out, halted, illegal
  );
endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational control-vector decode from state, op, fn and mem_ready.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  st_e                  state,
  input  logic [5:0]           op,
  input  logic [5:0]           fn,
  input  logic                 mem_ready,
  output logic [CTRL_BITS-1:0] ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      ST_FETCH: begin
        ctrl[B_MEMRD] = 1'b1;
        // IR and PC update only on the cycle the fetch lands
        if (mem_ready) begin
          ctrl[B_PCWR] = 1'b1;
          ctrl[B_IRWR] = 1'b1;
        end
      end
      ST_DECODE: begin
        ctrl[B_ALUY +: 2] = Y_IMM2;
      end
      ST_EXEC_R: begin
        ctrl[B_ALUX]      = 1'b1;
        ctrl[B_ALUY +: 2] = Y_RT;
        ctrl[B_ALUF +: 5] = r_alu(fn);
      end
      ST_WB_R: begin
        ctrl[B_REGWR]       = 1'b1;
        ctrl[B_REGDST +: 2] = RD_RD;
        ctrl[B_REGIN]       = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl[B_ALUX]      = 1'b1;
        ctrl[B_ALUY +: 2] = Y_IMM;
        ctrl[B_ALUF +: 5] = i_alu(op);
      end
      ST_WB_I: begin
        ctrl[B_REGWR] = 1'b1;
        ctrl[B_REGIN] = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctrl[B_ALUX]      = 1'b1;
        ctrl[B_ALUY +: 2] = Y_IMM;
      end
      ST_MEM_RD: begin
        ctrl[B_MEMRD] = 1'b1;
        ctrl[B_INSTD] = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl[B_REGWR] = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl[B_MEMWR] = 1'b1;
        ctrl[B_INSTD] = 1'b1;
      end
      ST_BRANCH: begin
        ctrl[B_BRANCH]     = 1'b1;
        ctrl[B_PCSRC +: 2] = PC_ALUOUT;
        ctrl[B_ALUX]       = 1'b1;
        ctrl[B_ALUY +: 2]  = Y_RT;
        ctrl[B_ALUF +: 5]  =
          (op == OP_BNE) ? ALU_SEQ : ALU_SUB;
      end
      ST_JAL_LINK: begin
        ctrl[B_ALUF +: 5] = ALU_PASSX;
      end
      ST_JUMP: begin
        ctrl[B_PCWR]       = 1'b1;
        ctrl[B_PCSRC +: 2] = PC_JTA;
        if (op == OP_JAL) begin
          ctrl[B_REGWR]       = 1'b1;
          ctrl[B_REGDST +: 2] = RD_R31;
          ctrl[B_REGIN]       = 1'b1;
        end
      end
      ST_JR: begin
        ctrl[B_PCWR]       = 1'b1;
        ctrl[B_PCSRC +: 2] = PC_RS;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: state register, sequencing, sticky flags.
// Build option: CTRL_TRAP_EN traps undefined op/fn instead of NOP.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CTRL_W = 22
) (
  input logic           clk,
  input logic           reset,
  mc_ctrl_fsm_if.master bus
);

  if (CTRL_W != CTRL_BITS) begin : g_bad_width
    $error("mc_ctrl_fsm: CTRL_W must be 22");
  end

  st_e                  state;
  st_e                  nxt;
  logic                 halt_q;
  logic [CTRL_BITS-1:0] dec_ctrl;

`ifdef CTRL_TRAP_EN
  localparam st_e ST_ILL = ST_TRAP;
  logic ill_q;

  always_ff @(posedge clk) begin
    if (reset)                ill_q <= 1'b0;
    else if (nxt == ST_TRAP)  ill_q <= 1'b1;
  end

  assign bus.illegal = ill_q;
`else
  localparam st_e ST_ILL = ST_FETCH;
  assign bus.illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FETCH;
      halt_q <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == ST_HALT) halt_q <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_FETCH:    if (bus.mem_ready) nxt = ST_DECODE;
      ST_DECODE: begin
        unique case (1'b1)
          bus.op_in == OP_R && r_legal(bus.fn_in):
            nxt = ST_EXEC_R;
          bus.op_in == OP_R && bus.fn_in == FN_JR:
            nxt = ST_JR;
          bus.op_in == OP_R && bus.fn_in == FN_SYS:
            nxt = ST_HALT;
          i_legal(bus.op_in):
            nxt = ST_EXEC_I;
          bus.op_in == OP_LW || bus.op_in == OP_SW:
            nxt = ST_MEM_ADDR;
          bus.op_in == OP_BEQ || bus.op_in == OP_BNE:
            nxt = ST_BRANCH;
          bus.op_in == OP_J:
            nxt = ST_JUMP;
          bus.op_in == OP_JAL:
            nxt = ST_JAL_LINK;
          default:
            nxt = ST_ILL;
        endcase
      end
      ST_EXEC_R:   nxt = ST_WB_R;
      ST_EXEC_I:   nxt = ST_WB_I;
      ST_MEM_ADDR:
        nxt = (bus.op_in == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (bus.mem_ready) nxt = ST_MEM_WB;
      ST_MEM_WR:   if (bus.mem_ready) nxt = ST_FETCH;
      ST_JAL_LINK: nxt = ST_JUMP;
      ST_WB_R, ST_WB_I, ST_MEM_WB,
      ST_BRANCH, ST_JUMP, ST_JR:
        nxt = ST_FETCH;
      default:     nxt = state;
    endcase
  end

  mc_ctrl_decode u_dec (
    .state     (state),
    .op        (bus.op_in),
    .fn        (bus.fn_in),
    .mem_ready (bus.mem_ready),
    .ctrl      (dec_ctrl)
  );

  assign bus.ctrl_out  = reset ? '0 : dec_ctrl;
  assign bus.state_out = state;
  assign bus.halted    = halt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized scoreboard bench for mc_ctrl_fsm (honours CTRL_TRAP_EN).
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if #(.CTRL_W(22)) bus ();

  mc_ctrl_fsm #(.CTRL_W(22)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [21:0] c;
    logic [3:0]  s;
    logic        h;
    logic        il;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Control word assembled field by field from the documented bit map
  function automatic logic [21:0] mk(
    bit pcw, bit idat, bit mr, bit mw, bit [1:0] pcs,
    bit br, bit irw, bit rw, bit [1:0] rd, bit ris,
    bit ax, bit [1:0] ay, bit [4:0] af);
    return {pcw, idat, mr, mw, pcs, br, irw, rw,
            rd, ris, 2'b00, ax, ay, af};
  endfunction

  function automatic logic [21:0] alu(
    bit ax, bit [1:0] ay, bit [4:0] af);
    return mk(0,0,0,0,0,0,0,0,0,0,ax,ay,af);
  endfunction

  function automatic bit [4:0] rmap(input logic [5:0] f);
    case (f)
      6'd32: return 5'd0;
      6'd34: return 5'd1;
      6'd36: return 5'd2;
      6'd37: return 5'd3;
      6'd38: return 5'd4;
      6'd39: return 5'd5;
      default: return 5'd6;
    endcase
  endfunction

  function automatic bit [4:0] imap(input logic [5:0] o);
    case (o)
      6'd8:  return 5'd0;
      6'd10: return 5'd6;
      6'd12: return 5'd2;
      6'd13: return 5'd3;
      6'd14: return 5'd4;
      default: return 5'd7;
    endcase
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input bit r, input logic [5:0] o,
                      input logic [5:0] f, input bit mr,
                      input logic [21:0] c, input st_e s,
                      input bit h, input bit il);
    exp_t e;
    reset         = r;
    bus.op_in     = o;
    bus.fn_in     = f;
    bus.mem_ready = mr;
    bus.alu_zero  = rb();
    e.c = c; e.s = s; e.h = h; e.il = il;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic sn(input logic [5:0] o, input logic [5:0] f,
                    input bit mr, input logic [21:0] c,
                    input st_e s);
    step(1'b0, o, f, mr, c, s, 1'b0, 1'b0);
  endtask

  task automatic fetch_dec(input logic [5:0] o,
                           input logic [5:0] f, input int fw);
    for (int i = 0; i < fw; i++)
      sn(6'($urandom), 6'($urandom), 1'b0,
         mk(0,0,1,0,0,0,0,0,0,0,0,0,0), ST_FETCH);
    sn(6'($urandom), 6'($urandom), 1'b1,
       mk(1,0,1,0,0,0,1,0,0,0,0,0,0), ST_FETCH);
    sn(o, f, rb(), alu(0, 2'd3, 5'd0), ST_DECODE);
  endtask

  task automatic ill_tail(input logic [5:0] o, input logic [5:0] f);
`ifdef CTRL_TRAP_EN
    for (int i = 0; i < 4; i++)
      step(1'b0, o, f, rb(), '0, ST_TRAP, 1'b0, 1'b1);
    step(1'b1, o, f, rb(), '0, ST_TRAP, 1'b0, 1'b1);
`else
    reset = 1'b0;
`endif
  endtask

  task automatic mem_wait(input logic [5:0] o, input int mw,
                          input int abort, input st_e s,
                          input logic [21:0] c, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < mw; i++) begin
      if (abort > 0 && i == abort) begin
        step(1'b1, o, 6'd0, 1'b0, '0, s, 1'b0, 1'b0);
        aborted = 1'b1;
        return;
      end
      sn(o, 6'd0, 1'b0, c, s);
    end
    sn(o, 6'd0, 1'b1, c, s);
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int fw, input int mw, input int abort);
    bit ab;
    fetch_dec(o, f, fw);
    case (o)
      6'd0: case (f)
        6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42: begin
          sn(o, f, rb(), alu(1, 2'd1, rmap(f)), ST_EXEC_R);
          sn(o, f, rb(), mk(0,0,0,0,0,0,0,1,1,1,0,0,0), ST_WB_R);
        end
        6'd8:
          sn(o, f, rb(), mk(1,0,0,0,3,0,0,0,0,0,0,0,0), ST_JR);
        6'd12: begin
          for (int i = 0; i < 11; i++)
            step(1'b0, o, f, rb(), '0, ST_HALT, 1'b1, 1'b0);
          step(1'b1, o, f, rb(), '0, ST_HALT, 1'b1, 1'b0);
        end
        default: ill_tail(o, f);
      endcase
      6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15: begin
        sn(o, f, rb(), alu(1, 2'd2, imap(o)), ST_EXEC_I);
        sn(o, f, rb(), mk(0,0,0,0,0,0,0,1,0,1,0,0,0), ST_WB_I);
      end
      6'd35: begin
        sn(o, f, rb(), alu(1, 2'd2, 5'd0), ST_MEM_ADDR);
        mem_wait(o, mw, abort, ST_MEM_RD,
                 mk(0,1,1,0,0,0,0,0,0,0,0,0,0), ab);
        if (!ab)
          sn(o, f, rb(), mk(0,0,0,0,0,0,0,1,0,0,0,0,0), ST_MEM_WB);
      end
      6'd43: begin
        sn(o, f, rb(), alu(1, 2'd2, 5'd0), ST_MEM_ADDR);
        mem_wait(o, mw, abort, ST_MEM_WR,
                 mk(0,1,0,1,0,0,0,0,0,0,0,0,0), ab);
      end
      6'd4, 6'd5:
        sn(o, f, rb(),
           mk(0,0,0,0,1,1,0,0,0,0,1,1, (o == 6'd5) ? 5'd8 : 5'd1),
           ST_BRANCH);
      6'd2:
        sn(o, f, rb(), mk(1,0,0,0,2,0,0,0,0,0,0,0,0), ST_JUMP);
      6'd3: begin
        sn(o, f, rb(), alu(0, 2'd0, 5'd9), ST_JAL_LINK);
        sn(o, f, rb(), mk(1,0,0,0,2,0,0,1,2,1,0,0,0), ST_JUMP);
      end
      default: ill_tail(o, f);
    endcase
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      me = sb.pop_front();
      n_chk++;
      if (bus.ctrl_out !== me.c) begin
        n_fail++;
        $display("FAIL ctrl_out t=%0t got %h want %h",
                 $time, bus.ctrl_out, me.c);
      end
      n_chk++;
      if (bus.state_out !== me.s) begin
        n_fail++;
        $display("FAIL state_out t=%0t got %0d want %0d",
                 $time, bus.state_out, me.s);
      end
      n_chk++;
      if (bus.halted !== me.h) begin
        n_fail++;
        $display("FAIL halted t=%0t got %b want %b",
                 $time, bus.halted, me.h);
      end
      n_chk++;
      if (bus.illegal !== me.il) begin
        n_fail++;
        $display("FAIL illegal t=%0t got %b want %b",
                 $time, bus.illegal, me.il);
      end
    end
  end

  logic [5:0] rfn[7] = '{6'd32, 6'd34, 6'd36, 6'd37,
                         6'd38, 6'd39, 6'd42};
  logic [5:0] iop[6] = '{6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15};

  initial begin
    bus.op_in     = '0;
    bus.fn_in     = '0;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    reset         = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 6'd0, 6'd0, 1'b1, '0, ST_FETCH, 1'b0, 1'b0);

    run_instr(6'd0, 6'd32, 0, 0, 0);
    run_instr(6'd35, 6'd0, 0, 2, 0);
    run_instr(6'd0, 6'd34, 3, 0, 0);
    run_instr(6'd3, 6'd0, 0, 0, 0);
    run_instr(6'd43, 6'd0, 1, 0, 0);
    run_instr(6'd35, 6'd0, 0, 3, 2);
    run_instr(6'd43, 6'd0, 0, 2, 1);
    run_instr(6'd4, 6'd0, 0, 0, 0);
    run_instr(6'd0, 6'd8, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      int         cls;
      logic [5:0] o;
      logic [5:0] f;
      cls = $urandom_range(0, 8);
      f   = 6'($urandom);
      case (cls)
        0: begin o = 6'd0; f = rfn[$urandom_range(0, 6)]; end
        1: o = iop[$urandom_range(0, 5)];
        2: o = 6'd35;
        3: o = 6'd43;
        4: o = 6'd4;
        5: o = 6'd5;
        6: o = 6'd2;
        7: o = 6'd3;
        default: begin o = 6'd0; f = 6'd8; end
      endcase
      run_instr(o, f, $urandom_range(0, 2),
                $urandom_range(0, 3), 0);
    end

    run_instr(6'd63, 6'd0, 0, 0, 0);
    run_instr(6'd0, 6'd0, 1, 0, 0);
    run_instr(6'd0, 6'd12, 0, 0, 0);
    run_instr(6'd0, 6'd42, 0, 0, 0);

    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
